// File: rtl/radix_multiplier_pkg.sv
// Shared types and Booth recoding for the pipelined radix-4 multiplier.
package radix_multiplier_pkg;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_encode(input logic [2:0] window);
        booth_digit_t digit;
        case (window)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: digit(window) * a, sign-extended to 2*WIDTH bits, unshifted.
module booth_pp_gen
    import radix_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [2:0]         window,
    output logic [2*WIDTH-1:0] pp
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] a_dbl;

    // Negation happens at full product width so the most-negative a cannot overflow.
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign a_dbl = a_ext << 1;

    always_comb begin
        pp = '0;
        case (booth_encode(window))
            POS1:    pp = a_ext;
            POS2:    pp = a_dbl;
            NEG1:    pp = -a_ext;
            NEG2:    pp = -a_dbl;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/radix_multiplier.sv
// Pipelined signed radix-4 Booth multiplier: one Booth digit accumulated per stage, one product per cycle.
module radix_multiplier
    import radix_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   final_result
);

    localparam int unsigned STAGES = WIDTH / 2;
    localparam int unsigned PW     = 2 * WIDTH;

    // a_s[k]/b_s[k] feed accumulation stage k+1; the last stage needs no forwarded copy.
    logic [WIDTH-1:0] a_s   [0:STAGES-1];
    logic [WIDTH-1:0] b_s   [0:STAGES-1];
    logic [PW-1:0]    sum_s [1:STAGES];
    logic [PW-1:0]    pp_sh [1:STAGES];

    for (genvar i = 1; i <= STAGES; i++) begin : g_pp
        logic [WIDTH:0] b_ext;
        logic [PW-1:0]  pp_raw;

        assign b_ext = {b_s[i-1], 1'b0};

        booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
            .a      (a_s[i-1]),
            .window (b_ext[2*i -: 3]),
            .pp     (pp_raw)
        );

        assign pp_sh[i] = pp_raw << (2 * (i - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_s[k] <= '0;
                b_s[k] <= '0;
            end
            for (int unsigned k = 1; k <= STAGES; k++) begin
                sum_s[k] <= '0;
            end
            final_result <= '0;
        end else begin
            a_s[0] <= a;
            b_s[0] <= b;
            for (int unsigned k = 1; k < STAGES; k++) begin
                a_s[k] <= a_s[k-1];
                b_s[k] <= b_s[k-1];
            end
            sum_s[1] <= pp_sh[1];
            for (int unsigned k = 2; k <= STAGES; k++) begin
                sum_s[k] <= sum_s[k-1] + pp_sh[k];
            end
            final_result <= sum_s[STAGES];
        end
    end

endmodule

// File: tb/tb_radix_multiplier.sv
// Scoreboard bench for radix_multiplier (WIDTH=4): expected products queued at sampling, compared at output.
module tb_radix_multiplier;

    localparam int unsigned W   = 4;
    localparam int unsigned LAT = W / 2 + 2;

    logic           clk;
    logic           rst;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] final_result;

    int checks;
    int errors;
    logic [2*W-1:0] exp_q [$];

    radix_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .final_result (final_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        logic signed [2*W-1:0] p;
        sa = {{W{av[W-1]}}, av};
        sb = {{W{bv[W-1]}}, bv};
        p  = sa * sb;
        return p;
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] expected);
        checks++;
        assert (final_result === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, final_result, expected);
        end
    endtask

    task automatic prime_zeros();
        exp_q.delete();
        for (int i = 0; i < int'(LAT) - 1; i++) exp_q.push_back('0);
    endtask

    // Drive operands, let the DUT sample them, then compare the oldest due result.
    task automatic cycle(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        logic [2*W-1:0] e;
        a = av;
        b = bv;
        @(posedge clk);
        exp_q.push_back(ref_mul(av, bv));
        @(negedge clk);
        if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            check(tag, e);
        end
    endtask

    initial begin
        logic [W-1:0] av;
        logic [W-1:0] bv;
        checks = 0;
        errors = 0;

        rst = 1'b1;
        a   = '0;
        b   = '0;
        #3 check("reset_async_start", '0);
        for (int i = 0; i < 9; i++) begin
            #10;
            check("reset_hold", '0);
        end
        @(negedge clk);
        rst = 1'b0;
        prime_zeros();

        cycle(4'b1010, 4'b0010, "post_reset_zero");
        for (int i = 0; i < 6; i++) cycle(4'b1010, 4'b0010, "basic_neg6x2_hold");
        // Independent spot check of the known constant for -6*2.
        check("basic_const_f4", 8'hF4);

        cycle(4'b1000, 4'b1000, "ext_m8xm8");
        cycle(4'b1000, 4'b0111, "ext_m8x7");
        cycle(4'b0111, 4'b0111, "ext_7x7");
        cycle(4'b0000, 4'b1111, "ext_0xm1");
        for (int i = 0; i < int'(LAT); i++) cycle(4'b0000, 4'b1111, "ext_flush");

        for (int i = 0; i < 16; i++) begin
            av = W'($urandom_range(0, 15));
            bv = W'($urandom_range(0, 15));
            cycle(av, bv, "b2b");
        end

        // Asynchronous reset between edges with products still in flight.
        #2 rst = 1'b1;
        #1 check("midstream_rst_immediate", '0);
        exp_q.delete();
        a = 4'b0111;
        b = 4'b0111;
        @(posedge clk);
        @(negedge clk);
        check("midstream_rst_held", '0);
        rst = 1'b0;
        prime_zeros();
        cycle(4'b0101, 4'b1101, "after_rst");
        cycle(4'b0011, 4'b1001, "after_rst");
        cycle(4'b1111, 4'b1111, "after_rst");
        cycle(4'b0110, 4'b0101, "after_rst");
        cycle(4'b1100, 4'b0011, "after_rst");

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                av = W'(ai);
                bv = W'(bi);
                cycle(av, bv, "exhaustive");
            end
        end
        for (int i = 0; i < int'(LAT); i++) cycle('0, '0, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/radix_multiplier.md
Name: radix_multiplier

Overview:
- Pipelined signed (two's-complement) radix-4 Booth multiplier: final_result = a * b.
- Operands are sampled every clock. The result appears a fixed number of cycles later.
- No handshake: a free-running datapath block used by BIST logic as a circuit-under-test.

Parameters:
- WIDTH, default 4: operand width in bits. Must be even and at least 4. Result width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears every register.
- a  input  WIDTH  multiplicand, two's-complement signed.
- b  input  WIDTH  multiplier (Booth-recoded), two's-complement signed.
- final_result  output  2*WIDTH  registered signed product a*b.

Behaviour:
- Reset:
  - While rst=1, all pipeline registers and final_result are 0, regardless of clk.
  - Clearing takes effect immediately on rst rising, without waiting for a clock edge.
- Pipeline structure:
  - Stage 0 registers a and b.
  - Stages 1..WIDTH/2 each add one Booth partial product into a 2*WIDTH-bit running sum and forward the registered operands.
  - A final stage registers final_result.
- Latency and throughput:
  - Latency is WIDTH/2+2 rising edges from operands stable at an edge to the result on final_result. This is 4 cycles for WIDTH=4.
  - Throughput is one product per cycle. Operands may change every cycle.
- Booth recoding:
  - Append b[-1]=0. Digit i (i=0..WIDTH/2-1) is formed from {b[2i+1], b[2i], b[2i-1]}.
  - Mapping: 000→0, 001→+1, 010→+1, 011→+2, 100→-2, 101→-1, 110→-1, 111→0.
- Partial products:
  - Partial product i = digit_i * a, sign-extended to 2*WIDTH bits and shifted left by 2i.
  - -1 and -2 are formed as the two's complement of a and 2a, computed at full 2*WIDTH width so that a = most-negative does not overflow.
- Arithmetic width:
  - All accumulation is modulo 2^(2*WIDTH).
  - The exact signed product always fits, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
- After reset release:
  - Pipeline registers hold zero operands, so final_result stays 0 until the first sampled operands emerge after the latency.
- Reset mid-operation:
  - All in-flight products are discarded and the output goes to 0.
  - No partial results appear after reset deassertion.
- Holding operands:
  - If a and b are held constant, final_result is stable and equals a*b after the latency, with no glitches between edges.
- X-propagation: no requirement beyond standard RTL semantics.

Decomposition:
- Package radix_multiplier_pkg holds:
  - enum booth_digit_t {ZERO, POS1, POS2, NEG1, NEG2};
  - function booth_encode(3-bit) returning booth_digit_t.
- Sub-module booth_pp_gen (parameter WIDTH):
  - Inputs: multiplicand and 3-bit recoding window.
  - Output: the 2*WIDTH-bit sign-extended, unshifted partial product.
  - Instantiated WIDTH/2 times, once per pipeline stage.
- Top level holds only the pipeline registers and adders.

Test Plan:
- Reset: rst=1 with a=0, b=0 for 100 ns, then deassert → final_result=8'h00 throughout reset and until the first result emerges.
- Basic signed case: rst=0, a=4'b1010 (-6), b=4'b0010 (2) → final_result=8'hF4 (-12) on the 4th rising edge after sampling, then stable.
- Extremes:
  - a=-8, b=-8 → 8'h40 (64).
  - a=-8, b=7 → 8'hC8 (-56).
  - a=7, b=7 → 8'h31 (49).
  - a=0, b=-1 → 8'h00.
- Back-to-back throughput: new operand pair each cycle for 16 cycles → each result appears exactly 4 cycles after its operands, in order, with no bubbles.
- Async reset mid-stream: assert rst between clock edges while products are in flight → final_result goes to 0 immediately. After release, 0 is held until the new products emerge with the 4-cycle latency.
- Exhaustive: all 256 (a,b) pairs, pipelined → every output matches the signed reference product.
